// File: rtl/vip_bin_pkg.sv
// vip_bin_pkg: accumulator/divider widths, divider cycle count and the FSM
// encoding shared by the gray binarizer and its divider.
package vip_bin_pkg;

    localparam int SUM_W      = 27;
    localparam int CNT_W      = 19;
    localparam int DIV_CYCLES = 27;
    localparam int DCNT_W     = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DIV   = 2'd2,
        ST_HOLD  = 2'd3
    } bin_state_e;

    // A mean of 8-bit samples never exceeds 255; clamp keeps the port width honest.
    function automatic logic [7:0] sat_u8(input logic [SUM_W-1:0] v);
        return (|v[SUM_W-1:8]) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/vip_gray_binarize_if.sv
// vip_gray_binarize_if: gray pixel stream in (per_*) and binary stream out (post_*).
// master drives pixels into the binarizer, slave is the binarizer itself.
interface vip_gray_binarize_if;

    logic       per_frame_vsync;
    logic       per_frame_href;
    logic       per_frame_clken;
    logic [7:0] per_img_Y;

    logic       post_frame_vsync;
    logic       post_frame_href;
    logic       post_frame_clken;
    logic       post_img_bit;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Y,
        input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Y,
        output post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit
    );

endinterface

// File: rtl/vip_seq_divider.sv
// vip_seq_divider: restoring divider, one quotient bit per clock over DIV_CYCLES
// clocks; done pulses for one clock with the saturated 8-bit quotient valid.
module vip_seq_divider
    import vip_bin_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [SUM_W-1:0] dividend_i,
    input  logic [CNT_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [7:0]       quotient_o
);

    logic [SUM_W-1:0]  quo_q, quo_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  dvs_q, dvs_d;
    logic [DCNT_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W:0]    rem_sh;
    logic              fits;

    // quo_q starts as the dividend and shifts quotient bits in from the bottom.
    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        rem_sh = {rem_q, quo_q[SUM_W-1]};
        fits   = (rem_sh >= {1'b0, dvs_q});
        if (busy_q) begin
            quo_d = {quo_q[SUM_W-2:0], fits};
            rem_d = fits ? CNT_W'(rem_sh - {1'b0, dvs_q}) : rem_sh[CNT_W-1:0];
            cnt_d = cnt_q - DCNT_W'(1);
            if (cnt_q == DCNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start_i) begin
            quo_d  = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
            cnt_d  = DCNT_W'(DIV_CYCLES);
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = sat_u8(quo_q);

endmodule

// File: rtl/vip_gray_binarize.sv
// vip_gray_binarize: 1-clock binarizer of a gray stream against thresh_o.
// Build macro VIP_BIN_ADAPTIVE_EN: thresh_o follows the mean luma of past frames.
//
// state    | meaning
// ST_IDLE  | no frame being summed, threshold stable
// ST_ACCUM | summing Y of the current frame
// ST_DIV   | dividing last frame's sum; a new frame may accumulate meanwhile
// ST_HOLD  | mean ready during an active frame; applied when that frame ends
module vip_gray_binarize
    import vip_bin_pkg::*;
#(
    parameter logic [9:0] IMG_HDISP      = 10'd640,
    parameter logic [9:0] IMG_VDISP      = 10'd480,
    parameter logic [7:0] DEFAULT_THRESH = 8'd128
) (
    input  logic                      clk,
    input  logic                      rst_n,
    vip_gray_binarize_if.slave        vid,
    output logic [7:0]                thresh_o,
    output logic                      thresh_upd
);

    if (int'(IMG_HDISP) * int'(IMG_VDISP) >= (1 << CNT_W)) begin : g_geom_chk
        $error("vip_gray_binarize: frame size exceeds pixel counter width");
    end

    logic       vsync_q, href_q, clken_q;
    logic [7:0] y_q;
    logic [7:0] thresh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            clken_q <= 1'b0;
            y_q     <= '0;
        end else begin
            vsync_q <= vid.per_frame_vsync;
            href_q  <= vid.per_frame_href;
            clken_q <= vid.per_frame_clken;
            y_q     <= vid.per_img_Y;
        end
    end

    assign vid.post_frame_vsync = vsync_q;
    assign vid.post_frame_href  = href_q;
    assign vid.post_frame_clken = clken_q;
    assign vid.post_img_bit     = href_q && (y_q > thresh_q);
    assign thresh_o             = thresh_q;

`ifdef VIP_BIN_ADAPTIVE_EN
    bin_state_e       state_q, state_d;
    logic             vsync_qq, armed_q, act_q, act_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       thresh_d, pend_q, pend_d;
    logic             upd_q, upd_d;
    logic             frame_start, frame_end, pix_ok;
    logic             div_req, div_start, div_busy, div_done;
    logic [7:0]       div_quot;

    // armed_q ignores a frame already running when reset was released.
    assign frame_start = vsync_q & ~vsync_qq & armed_q;
    assign frame_end   = ~vsync_q & vsync_qq;
    assign pix_ok      = vsync_q & href_q & clken_q;
    assign div_start   = div_req & ~div_busy;

    always_comb begin
        act_d = act_q;
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (frame_start) begin
            act_d = 1'b1;
            sum_d = pix_ok ? SUM_W'(y_q) : '0;
            cnt_d = pix_ok ? CNT_W'(1) : '0;
        end else if (frame_end) begin
            act_d = 1'b0;
        end else if (act_q && pix_ok) begin
            sum_d = sum_q + SUM_W'(y_q);
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        thresh_d = thresh_q;
        pend_d   = pend_q;
        upd_d    = 1'b0;
        div_req  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (frame_end) begin
                    div_req = (cnt_q != '0);
                    state_d = (cnt_q != '0) ? ST_DIV : ST_IDLE;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    if (act_q && !frame_end) begin
                        pend_d  = div_quot;
                        state_d = ST_HOLD;
                    end else begin
                        thresh_d = div_quot;
                        upd_d    = 1'b1;
                        if (frame_end && act_q && cnt_q != '0) begin
                            div_req = 1'b1;
                            state_d = ST_DIV;
                        end else if (frame_start) begin
                            state_d = ST_ACCUM;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (frame_end) begin
                    thresh_d = pend_q;
                    upd_d    = 1'b1;
                    div_req  = (cnt_q != '0);
                    state_d  = (cnt_q != '0) ? ST_DIV : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            vsync_qq <= 1'b0;
            armed_q  <= 1'b0;
            act_q    <= 1'b0;
            sum_q    <= '0;
            cnt_q    <= '0;
            thresh_q <= DEFAULT_THRESH;
            pend_q   <= '0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            vsync_qq <= vsync_q;
            armed_q  <= armed_q | ~vid.per_frame_vsync;
            act_q    <= act_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            thresh_q <= thresh_d;
            pend_q   <= pend_d;
            upd_q    <= upd_d;
        end
    end

    vip_seq_divider u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start),
        .dividend_i (sum_q),
        .divisor_i  (cnt_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );

    assign thresh_upd = upd_q;
`else
    assign thresh_q   = DEFAULT_THRESH;
    assign thresh_upd = 1'b0;
`endif

endmodule

// File: tb/tb_vip_gray_binarize.sv
// tb_vip_gray_binarize: directed vectors with hand-computed thresholds and bits;
// the adaptive scenarios run only when VIP_BIN_ADAPTIVE_EN is defined.
module tb_vip_gray_binarize;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] thresh_o;
    logic       thresh_upd;
    int         n_chk    = 0;
    int         n_bad    = 0;
    int         upd_cnt  = 0;
    int         ones_cnt = 0;

    vip_gray_binarize_if vif();

    vip_gray_binarize dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vid        (vif),
        .thresh_o   (thresh_o),
        .thresh_upd (thresh_upd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (thresh_upd === 1'b1) upd_cnt++;
        if (vif.post_img_bit === 1'b1) ones_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: sim time limit reached, summary not produced");
        $fatal(1);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic h, input logic c, input logic [7:0] y);
        vif.per_frame_vsync = v;
        vif.per_frame_href  = h;
        vif.per_frame_clken = c;
        vif.per_img_Y       = y;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    // Even columns carry y0, odd columns y1.
    task automatic send_frame(input int w, input int h, input logic [7:0] y0,
                              input logic [7:0] y1, input int hblank);
        drive(1'b1, 1'b0, 1'b0, 8'd0);
        for (int l = 0; l < h; l++) begin
            for (int p = 0; p < w; p++) drive(1'b1, 1'b1, 1'b1, (p % 2 == 0) ? y0 : y1);
            for (int b = 0; b < hblank; b++) drive(1'b1, 1'b0, 1'b0, 8'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

`ifdef VIP_BIN_ADAPTIVE_EN
    task automatic wait_upd(input string tag, input int max_cyc, input int exp_thresh);
        int n = 0;
        while (thresh_upd !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, int'(thresh_upd === 1'b1), 1);
        chk({tag, "_val"}, int'(thresh_o), exp_thresh);
        @(negedge clk);
        chk({tag, "_pulse_w"}, int'(thresh_upd), 0);
    endtask
`endif

    initial begin
        int base_u;
        int base_o;

        vif.per_frame_vsync = 1'b1;
        vif.per_frame_href  = 1'b1;
        vif.per_frame_clken = 1'b1;
        vif.per_img_Y       = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vsync", int'(vif.post_frame_vsync), 0);
        chk("rst_href",  int'(vif.post_frame_href), 0);
        chk("rst_clken", int'(vif.post_frame_clken), 0);
        chk("rst_bit",   int'(vif.post_img_bit), 0);
        chk("rst_thr",   int'(thresh_o), 128);
        chk("rst_upd",   int'(thresh_upd), 0);

        vif.per_frame_vsync = 1'b0;
        vif.per_frame_href  = 1'b0;
        vif.per_frame_clken = 1'b0;
        vif.per_img_Y       = 8'd0;
        rst_n = 1'b1;
        idle(2);

        drive(1'b0, 1'b1, 1'b1, 8'd129);
        chk("y129_bit",  int'(vif.post_img_bit), 1);
        chk("y129_href", int'(vif.post_frame_href), 1);
        chk("y129_clk",  int'(vif.post_frame_clken), 1);
        drive(1'b0, 1'b1, 1'b1, 8'd128);
        chk("y128_bit",  int'(vif.post_img_bit), 0);
        drive(1'b0, 1'b1, 1'b0, 8'd255);
        chk("y255_noclken_bit", int'(vif.post_img_bit), 1);
        chk("y255_noclken_clk", int'(vif.post_frame_clken), 0);
        drive(1'b0, 1'b0, 1'b1, 8'd255);
        chk("nohref_bit",  int'(vif.post_img_bit), 0);
        chk("nohref_href", int'(vif.post_frame_href), 0);
        drive(1'b1, 1'b0, 1'b0, 8'd0);
        chk("vsync_dly", int'(vif.post_frame_vsync), 1);
        drive(1'b0, 1'b1, 1'b1, 8'd0);
        chk("y0_bit", int'(vif.post_img_bit), 0);
        chk("vsync_fall_dly", int'(vif.post_frame_vsync), 0);
        idle(40);
        chk("thr_after_empty", int'(thresh_o), 128);

`ifndef VIP_BIN_ADAPTIVE_EN
        // Reduced frame geometry keeps the run short; the threshold path is the same.
        base_u = upd_cnt;
        base_o = ones_cnt;
        send_frame(64, 8, 8'd10, 8'd10, 4);
        idle(40);
        chk("fix_y10_ones", ones_cnt - base_o, 0);
        chk("fix_y10_thr",  int'(thresh_o), 128);
        chk("fix_y10_upd",  upd_cnt - base_u, 0);
        base_o = ones_cnt;
        send_frame(4, 2, 8'd200, 8'd129, 2);
        idle(40);
        chk("fix_hi_ones", ones_cnt - base_o, 8);
        base_o = ones_cnt;
        send_frame(4, 2, 8'd128, 8'd0, 2);
        idle(40);
        chk("fix_eq_ones", ones_cnt - base_o, 0);
        chk("fix_thr_end", int'(thresh_o), 128);
        chk("fix_upd_end", upd_cnt - base_u, 0);
`else
        base_u = upd_cnt;
        send_frame(4, 2, 8'd60, 8'd60, 2);
        idle(20);
        chk("m60_early_thr", int'(thresh_o), 128);
        chk("m60_early_upd", upd_cnt - base_u, 0);
        wait_upd("m60", 40, 60);
        base_u = upd_cnt;
        drive(1'b1, 1'b0, 1'b0, 8'd0);
        drive(1'b1, 1'b1, 1'b1, 8'd61);
        chk("y61_bit", int'(vif.post_img_bit), 1);
        drive(1'b1, 1'b1, 1'b1, 8'd60);
        chk("y60_bit", int'(vif.post_img_bit), 0);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        chk("m60b_single", upd_cnt - base_u, 0);
        wait_upd("m60b", 40, 60);

        // 23 / 2 floors to 11
        send_frame(2, 1, 8'd10, 8'd13, 0);
        wait_upd("m11", 40, 11);
        drive(1'b0, 1'b1, 1'b1, 8'd12);
        chk("y12_bit", int'(vif.post_img_bit), 1);
        drive(1'b0, 1'b1, 1'b1, 8'd11);
        chk("y11_bit", int'(vif.post_img_bit), 0);

        // Out-of-frame pixels must not bleed into the next mean.
        drive(1'b0, 1'b1, 1'b1, 8'd255);
        drive(1'b0, 1'b1, 1'b1, 8'd255);
        send_frame(2, 1, 8'd20, 8'd20, 0);
        wait_upd("m20", 40, 20);

        base_u = upd_cnt;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 8'd200);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        idle(40);
        chk("noclken_upd", upd_cnt - base_u, 0);
        chk("noclken_thr", int'(thresh_o), 20);

        send_frame(4, 2, 8'd90, 8'd90, 2);
        idle(10);
        rst_n = 1'b0;
        #1;
        chk("rst_div_thr", int'(thresh_o), 128);
        chk("rst_div_upd", int'(thresh_upd), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        base_u = upd_cnt;
        idle(60);
        chk("rst_div_after_upd", upd_cnt - base_u, 0);
        chk("rst_div_after_thr", int'(thresh_o), 128);

        base_u = upd_cnt;
        send_frame(4, 1, 8'd200, 8'd200, 2);
        idle(3);
        send_frame(4, 2, 8'd100, 8'd100, 20);
        chk("holdB_thr", int'(thresh_o), 128);
        chk("holdB_upd", upd_cnt - base_u, 0);
        wait_upd("applyA", 10, 200);
        wait_upd("meanB", 40, 100);

        // Frame cut by reset is dropped; the next full frame sets the mean.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 8'd250);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_thr", int'(thresh_o), 128);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        base_u = upd_cnt;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 8'd250);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        idle(40);
        chk("rst_mid_upd", upd_cnt - base_u, 0);
        chk("rst_mid_thr2", int'(thresh_o), 128);
        send_frame(2, 1, 8'd40, 8'd40, 0);
        wait_upd("m40", 40, 40);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/vip_gray_binarize.md
VIP_GRAY_BINARIZE -- requirements
Module: vip_gray_binarize

Interface
REQ-001 Parameter IMG_HDISP, default 10'd640, active pixels per line (sizes counters).
REQ-002 Parameter IMG_VDISP, default 10'd480, active lines per frame (sizes counters).
REQ-003 Parameter DEFAULT_THRESH, default 8'd128, threshold used after reset and in fixed mode.
REQ-004 clk  input  1  pixel clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 per_frame_vsync  input  1  high for the whole active frame (median-filter output stream).
REQ-007 per_frame_href  input  1  high during active line.
REQ-008 per_frame_clken  input  1  pixel-valid strobe.
REQ-009 per_img_Y  input  8  filtered gray pixel.
REQ-010 post_frame_vsync / post_frame_href / post_frame_clken  output  1 each  inputs delayed 1 clock.
REQ-011 post_img_bit  output  1  binary pixel; 0 whenever post_frame_href is low.
REQ-012 thresh_o  output  8  threshold currently applied.
REQ-013 thresh_upd  output  1  one-clock pulse when thresh_o changes.

Function
REQ-014 Latency SHALL be exactly 1 clock from inputs to all post_* outputs.
REQ-015 post_img_bit SHALL be 1 iff registered per_img_Y > thresh_o and href high; equality gives 0.
REQ-016 Frame start SHALL be vsync rising edge; frame end SHALL be vsync falling edge (edge detection on registered vsync).
REQ-017 A pixel SHALL be accumulated only when href & clken are both high: sum (27 bit) += Y, count (19 bit) += 1.
REQ-018 Frame start SHALL clear sum and count in the same clock the first pixel may be accepted (first pixel included).
REQ-019 FSM states: IDLE, ACCUM, DIV, HOLD; IDLE->ACCUM on frame start; ACCUM->DIV on frame end with count!=0; ACCUM->IDLE on frame end with count==0 (threshold unchanged).
REQ-020 On ACCUM->DIV the sum/count SHALL be latched as divider operands, freeing accumulators for the next frame.
REQ-021 DIV SHALL run a restoring divider, one quotient bit per clock, 27 clocks; quotient >255 clamps to 255 (cannot occur for legal input).
REQ-022 DIV done with vsync low: thresh_o <= quotient next clock, thresh_upd pulses, ->IDLE.
REQ-023 DIV done with vsync high (new frame started): quotient stored pending, ->HOLD; thresh_o SHALL NOT change mid-frame.
REQ-024 In HOLD, pending value SHALL be applied at the next frame end, thresh_upd pulses; that frame's own mean is then computed (->DIV) and overwrites later.
REQ-025 Frame start during DIV SHALL start accumulation in parallel; divider is not disturbed.
REQ-026 Pixels arriving with vsync low SHALL be binarized but not accumulated.

Reset
REQ-027 On rst_n low: all post_* = 0, thresh_o = DEFAULT_THRESH, thresh_upd = 0, sum = count = 0, FSM = IDLE, pending cleared.
REQ-028 Reset mid-frame or mid-divide SHALL discard partial results; first frame after release accumulates normally from its rising vsync edge.

Configuration
REQ-029 Macro VIP_BIN_ADAPTIVE_EN defined: adaptive mean threshold per REQ-016..026.
REQ-030 Macro undefined: accumulator, FSM and divider not built; thresh_o constant DEFAULT_THRESH; thresh_upd tied 0; REQ-014/015 unchanged.

Structure
REQ-031 Package vip_bin_pkg SHALL hold SUM_W=27, CNT_W=19, DIV_CYCLES=27, FSM state enum.
REQ-032 Divider SHALL be sub-module vip_seq_divider (start/busy/done, 27-bit dividend, 19-bit divisor, 8-bit saturated quotient).

Verification
REQ-033 Reset release, pixel Y=129 with href/clken -> next clock post_img_bit=1; Y=128 -> 0; thresh_o=128.
REQ-034 Frame of 4x2 pixels all Y=60, vsync falls -> after 27+1 clocks thresh_o=60, thresh_upd one pulse; next frame Y=61 ->1, Y=60 ->0.
REQ-035 Frame with vsync high but no clken pulses -> thresh_o unchanged, no thresh_upd.
REQ-036 Frame A mean 200, frame B starts 3 clocks after A ends -> thresh_o stays 128 through B, becomes 200 at B's end, then B's mean 28 clocks later.
REQ-037 rst_n asserted during DIV -> thresh_o=128 immediately, no thresh_upd after release.
REQ-038 Build without VIP_BIN_ADAPTIVE_EN, full 640x480 frame Y=10 -> thresh_o stays 128, all bits 0.
